gpio_bus_arbiter: RTL and testbench
===================================

Name: gpio_bus_arbiter

Overview:
- Two-requester Wishbone-classic arbiter in front of the 8-bit GPIO peripheral register port (2-bit address, 8-bit data, single-cycle registered ack).
- Shares that port between the CPU data bus (m0) and a second master such as a debug or DMA engine (m1).
- Arbitration is round-robin with a bounded-wait timeout.
- Sequences the slave so every transfer is cleanly separated: cyc is forced low for at least one cycle after each ack.

Parameters:
- AW, 2, address width of slave register port
- DW, 8, data width
- TIMEOUT, 15, cycles in a grant state without slave ack before forced release; legal range 2..255

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0_addr  in  AW  master 0 address
- m0_dat  in  DW  master 0 write data
- m0_we  in  1  master 0 write enable
- m0_cyc  in  1  master 0 request; held until m0_ack or m0_err
- m0_rdt  out  DW  master 0 read data
- m0_ack  out  1  master 0 transfer complete
- m0_err  out  1  master 0 timeout error
- m1_*  same set as m0_* for master 1
- s_addr  out  AW  to slave
- s_dat  out  DW  to slave
- s_we  out  1  to slave
- s_cyc  out  1  to slave
- s_rdt  in  DW  from slave
- s_ack  in  1  from slave
- grant  out  2  one-hot current owner; 00 when none
- busy  out  1  high in BUS0/BUS1

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- States: IDLE, BUS0, BUS1, RELEASE. Encoding is free.
- Registered state:
  - state
  - last, 1 bit: last granted master
  - tcnt, width clog2(TIMEOUT+1)
- Reset (sampled on a clk edge with rst=1):
  - state=IDLE, last=1, tcnt=0.
  - All outputs are 0 from the following cycle.
  - Reset mid-transfer drops s_cyc with no ack or err to either master.
- Arbitration occurs only in IDLE and RELEASE:
  - only m0_cyc -> BUS0; only m1_cyc -> BUS1
  - both -> the master != last
  - none -> IDLE
  - On entering BUSn: last<=n, tcnt<=0.
- BUSn outputs (combinational from state):
  - s_cyc=mn_cyc; s_addr/s_dat/s_we = master n's signals.
  - mn_ack=s_ack; mn_rdt=s_rdt.
  - grant bit n=1; busy=1.
- BUSn transitions:
  - s_ack=1 -> RELEASE.
  - Else mn_cyc=0 (abort) -> IDLE, with no ack or err.
  - Else tcnt==TIMEOUT-1 -> mn_err=1 for this one cycle (combinational), then RELEASE.
  - Else tcnt<=tcnt+1.
- Non-BUS states: s_cyc=0; s_addr, s_dat, s_we = 0; grant=00; busy=0.
- Ungranted master, in any state: ack=0, err=0, rdt=0.
- RELEASE exists because the slave's ack toggles when cyc stays high. It guarantees s_cyc=0 for at least one cycle between transfers. It arbitrates exactly like IDLE.
- Latency, request seen in IDLE at edge k:
  - grant at cycle k+1
  - slave ack, and therefore master ack, at k+2
  - RELEASE at k+3
  - next grant earliest at k+4
- s_ack arriving while not in BUSn is ignored.
- Write data and we are held to the slave through the ack cycle; the slave commits writes on we&ack.
- A master that raises cyc in the same cycle as the other's RELEASE is eligible immediately.

Test Plan:
- m0 read, addr=0, slave stub returns 8'hA5 with ack one cycle after cyc -> grant=01 at k+1; m0_ack=1 and m0_rdt=A5 at k+2; s_cyc=0 at k+3; m1 outputs 0 throughout.
- m0 and m1 both request writes from reset (m0: addr=1, dat=8'h3C; m1: addr=2, dat=8'hF0) -> m0 served first. s_we=1, s_addr=1, s_dat=3C through its ack cycle. Then RELEASE, then m1 served with addr=2, dat=F0. grant sequence 01,00,10.
- Both masters hold continuous back-to-back requests for 8 transfers -> grants strictly alternate (4 each); s_cyc low at least 1 cycle between every ack.
- Slave stub never acks, m1 requests, TIMEOUT=15 -> m1_err=1 for exactly one cycle, 15 cycles after grant. No m1_ack. Next cycle RELEASE with s_cyc=0.
- m0 granted, m0 drops cyc before ack -> IDLE next cycle, no ack or err; a pending m1 request is granted the following cycle.
- rst=1 asserted in BUS1 cycle -> next cycle s_cyc=0, grant=00. After release of rst, simultaneous requests grant m0 first (last=1).

Source files
------------

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: round-robin two-master Wishbone-classic arbiter for the
// 8-bit GPIO register port. Each granted transfer is bounded by TIMEOUT
// cycles, and s_cyc is held low for at least one cycle between transfers.
module gpio_bus_arbiter #(
  parameter int AW      = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_dat,
  input  logic          m0_we,
  input  logic          m0_cyc,
  output logic [DW-1:0] m0_rdt,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_dat,
  input  logic          m1_we,
  input  logic          m1_cyc,
  output logic [DW-1:0] m1_rdt,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_dat,
  output logic          s_we,
  output logic          s_cyc,
  input  logic [DW-1:0] s_rdt,
  input  logic          s_ack,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUS0    = 2'd1;
  localparam logic [1:0] BUS1    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]    state, state_nxt;
  logic          last, last_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [1:0]    arb_state;
  logic          own_cyc;
  logic          tmo;

  assign own_cyc = (state == BUS0) ? m0_cyc : m1_cyc;
  assign tmo     = (tcnt == TW'(TIMEOUT - 1));

  // Round-robin pick: on contention the master not served last wins.
  always_comb begin
    arb_state = IDLE;
    if (m0_cyc && m1_cyc) arb_state = last ? BUS0 : BUS1;
    else if (m0_cyc)      arb_state = BUS0;
    else if (m1_cyc)      arb_state = BUS1;
  end

  // Next-state, last-owner and timeout-counter logic.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE, RELEASE: begin
        state_nxt = arb_state;
        if (arb_state == BUS0) begin
          last_nxt = 1'b0;
          tcnt_nxt = '0;
        end else if (arb_state == BUS1) begin
          last_nxt = 1'b1;
          tcnt_nxt = '0;
        end
      end
      BUS0, BUS1: begin
        if (s_ack)        state_nxt = RELEASE;
        else if (!own_cyc) state_nxt = IDLE;
        else if (tmo)     state_nxt = RELEASE;
        else              tcnt_nxt  = tcnt + TW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers with synchronous reset; last=1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // Bus steering: outputs decode from state; ungranted master sees all zeros.
  always_comb begin
    s_addr = '0;
    s_dat  = '0;
    s_we   = 1'b0;
    s_cyc  = 1'b0;
    m0_rdt = '0;
    m0_ack = 1'b0;
    m0_err = 1'b0;
    m1_rdt = '0;
    m1_ack = 1'b0;
    m1_err = 1'b0;
    grant  = 2'b00;
    busy   = 1'b0;
    case (state)
      BUS0: begin
        s_cyc  = m0_cyc;
        s_addr = m0_addr;
        s_dat  = m0_dat;
        s_we   = m0_we;
        m0_ack = s_ack;
        m0_rdt = s_rdt;
        m0_err = !s_ack && m0_cyc && tmo;
        grant  = 2'b01;
        busy   = 1'b1;
      end
      BUS1: begin
        s_cyc  = m1_cyc;
        s_addr = m1_addr;
        s_dat  = m1_dat;
        s_we   = m1_we;
        m1_ack = s_ack;
        m1_rdt = s_rdt;
        m1_err = !s_ack && m1_cyc && tmo;
        grant  = 2'b10;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Testbench for gpio_bus_arbiter: directed latency/reset/abort/timeout cases,
// then randomized two-master traffic checked by a scoreboard monitor.
module tb_gpio_bus_arbiter;

  localparam int AW      = 2;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;
  localparam int NTX     = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_dat, m1_dat, s_dat;
  logic          m0_we, m1_we, s_we;
  logic          m0_cyc, m1_cyc, s_cyc;
  logic [DW-1:0] m0_rdt, m1_rdt, s_rdt;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic          s_ack;
  logic [1:0]    grant;
  logic          busy;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic          err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  logic mon_en = 1'b0;
  logic done = 1'b0;
  logic last_m = 1'b1;

  always #5 clk = ~clk;

  gpio_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_dat(m0_dat), .m0_we(m0_we), .m0_cyc(m0_cyc),
    .m0_rdt(m0_rdt), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_dat(m1_dat), .m1_we(m1_we), .m1_cyc(m1_cyc),
    .m1_rdt(m1_rdt), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_dat(s_dat), .s_we(s_we), .s_cyc(s_cyc),
    .s_rdt(s_rdt), .s_ack(s_ack), .grant(grant), .busy(busy)
  );

  // Slave stub: fixed read pattern per register; address 3 never acks.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return 8'hA5 ^ {4{a}};
  endfunction

  assign s_rdt = rom(s_addr);

  always @(posedge clk) begin
    if (rst) s_ack <= 1'b0;
    else     s_ack <= s_cyc && !s_ack && (s_addr != 2'd3);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got no valid response, expected one at %0t", nm, $time);
  endtask

  // Advance to the sampling point of the next clock cycle.
  task automatic nc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int n, input logic c, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic w);
    if (n == 0) begin m0_cyc = c; m0_addr = a; m0_dat = d; m0_we = w; end
    else        begin m1_cyc = c; m1_addr = a; m1_dat = d; m1_we = w; end
  endtask

  task automatic check_master(input int n, input logic ack, input logic err,
                              input logic [DW-1:0] rdt, input logic gbit,
                              input int unsigned gc);
    exp_t e;
    if (!gbit) chk($sformatf("ungranted_m%0d", n), 32'({ack, err, rdt}), 32'h0);
    if (ack || err) begin
      if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
        bad($sformatf("spurious_m%0d", n));
      end else begin
        if (n == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("resp_kind_m%0d", n), 32'({ack, err}), e.err ? 32'h1 : 32'h2);
        if (ack) begin
          chk("s_we", 32'(s_we), 32'(e.we));
          chk("s_addr", 32'(s_addr), 32'(e.addr));
          if (e.we) chk("s_dat", 32'(s_dat), 32'(e.dat));
          else      chk($sformatf("rdt_m%0d", n), 32'(rdt), 32'(rom(e.addr)));
          chk("ack_latency", 32'(gc), 32'h2);
        end else begin
          chk("tmo_latency", 32'(gc), 32'(TIMEOUT));
        end
      end
    end
  endtask

  // Scoreboard monitor: arbitration order, bus gaps, responses, latencies.
  task automatic monitor();
    logic [1:0]  pg = 2'b00;
    int unsigned gc = 0;
    logic        pc0 = 1'b0, pc1 = 1'b0, pdone = 1'b0, eo;
    while (!done) begin
      @(negedge clk);
      if (grant != 2'b00) gc = (grant == pg) ? gc + 1 : 1;
      else                gc = 0;
      if (mon_en) begin
        if (pdone) chk("gap_scyc", 32'(s_cyc), 32'h0);
        if (grant != 2'b00 && pg == 2'b00) begin
          if (pc0 && pc1) eo = !last_m;
          else            eo = !pc0;
          chk("arb_grant", 32'(grant), eo ? 32'h2 : 32'h1);
          last_m = eo;
        end
        check_master(0, m0_ack, m0_err, m0_rdt, grant[0], gc);
        check_master(1, m1_ack, m1_err, m1_rdt, grant[1], gc);
      end
      pdone = m0_ack | m0_err | m1_ack | m1_err;
      pg    = grant;
      pc0   = m0_cyc;
      pc1   = m1_cyc;
    end
  endtask

  // Random master: holds each request until ack/err, often back-to-back.
  task automatic master(input int n);
    exp_t e;
    int unsigned idle, r, b;
    logic got;
    for (int i = 0; i < NTX; i++) begin
      idle = $urandom_range(0, 2);
      if (idle != 0) begin
        drive(n, 1'b0, '0, '0, 1'b0);
        repeat (idle) begin @(posedge clk); #1; end
      end
      r      = $urandom_range(0, 9);
      e.addr = (r == 0) ? 2'd3 : AW'(r % 3);
      e.we   = 1'($urandom_range(0, 1));
      e.dat  = DW'($urandom_range(0, 255));
      e.err  = (e.addr == 2'd3);
      if (n == 0) q0.push_back(e);
      else        q1.push_back(e);
      drive(n, 1'b1, e.addr, e.dat, e.we);
      b   = 0;
      got = 1'b0;
      while (!got && b < 100) begin
        @(negedge clk);
        got = (n == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
        b++;
      end
      if (!got) bad($sformatf("wait_m%0d", n));
      @(posedge clk); #1;
    end
    drive(n, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_scyc", 32'(s_cyc), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_resp", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);

    // Single m0 read of address 0.
    @(posedge clk); #1 drive(0, 1'b1, 2'd0, 8'h00, 1'b0);
    nc();
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_scyc", 32'(s_cyc), 32'h1);
    chk("rd_m1_idle", 32'({m1_ack, m1_err, m1_rdt}), 32'h0);
    nc();
    chk("rd_ack", 32'(m0_ack), 32'h1);
    chk("rd_rdt", 32'(m0_rdt), 32'hA5);
    chk("rd_m1_idle2", 32'({m1_ack, m1_err, m1_rdt}), 32'h0);
    @(posedge clk); #1 drive(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("rd_release_scyc", 32'(s_cyc), 32'h0);
    chk("rd_release_grant", 32'(grant), 32'h0);

    // Simultaneous writes straight after reset: m0 first, then m1.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    drive(0, 1'b1, 2'd1, 8'h3C, 1'b1);
    drive(1, 1'b1, 2'd2, 8'hF0, 1'b1);
    nc();
    chk("wr0_grant", 32'(grant), 32'h1);
    chk("wr0_bus", 32'({s_we, s_addr, s_dat}), 32'({1'b1, 2'd1, 8'h3C}));
    nc();
    chk("wr0_ack", 32'({m0_ack, m1_ack}), 32'h2);
    chk("wr0_bus_ack", 32'({s_we, s_addr, s_dat}), 32'({1'b1, 2'd1, 8'h3C}));
    @(posedge clk); #1 drive(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("wr_release_grant", 32'(grant), 32'h0);
    chk("wr_release_scyc", 32'(s_cyc), 32'h0);
    nc();
    chk("wr1_grant", 32'(grant), 32'h2);
    chk("wr1_bus", 32'({s_we, s_addr, s_dat}), 32'({1'b1, 2'd2, 8'hF0}));
    nc();
    chk("wr1_ack", 32'({m0_ack, m1_ack}), 32'h1);

    // Abort: m0 drops cyc before any ack while m1 waits.
    @(posedge clk); #1
    drive(1, 1'b0, '0, '0, 1'b0);
    drive(0, 1'b1, 2'd3, 8'h00, 1'b0);
    nc();
    chk("ab_grant", 32'(grant), 32'h1);
    @(posedge clk); #1
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b1, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("ab_drop", 32'({s_cyc, m0_ack, m0_err}), 32'h0);
    nc();
    chk("ab_idle", 32'({grant, m0_err, m0_ack}), 32'h0);
    nc();
    chk("ab_m1_grant", 32'(grant), 32'h2);
    nc();
    chk("ab_m1_ack", 32'({m1_ack, m1_rdt}), 32'({1'b1, 8'hA5}));

    // Reset during BUS1, then tie goes to m0, then m1 times out.
    @(posedge clk); #1 drive(1, 1'b1, 2'd3, 8'h00, 1'b0);
    nc();
    chk("rb_grant", 32'(grant), 32'h2);
    @(posedge clk); #1 rst = 1'b1;
    nc();
    chk("rb_reset", 32'({s_cyc, grant, busy, m1_ack, m1_err}), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    drive(0, 1'b1, 2'd0, 8'h00, 1'b0);
    nc();
    chk("rb_tie_grant", 32'(grant), 32'h1);
    nc();
    chk("rb_m0_ack", 32'(m0_ack), 32'h1);
    @(posedge clk); #1 drive(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("rb_release", 32'(grant), 32'h0);
    for (int j = 1; j <= TIMEOUT; j++) begin
      nc();
      if (j == 1) chk("to_grant", 32'(grant), 32'h2);
      chk($sformatf("to_err_c%0d", j), 32'({m1_err, m1_ack}), (j == TIMEOUT) ? 32'h2 : 32'h0);
    end
    @(posedge clk); #1 drive(1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("to_release", 32'({s_cyc, grant, m1_err}), 32'h0);

    // Randomized traffic from both masters.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    last_m = 1'b1;
    mon_en = 1'b1;
    fork
      master(0);
      master(1);
    join
    repeat (8) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    mon_en = 1'b0;
    done   = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
